nexys4_seg_scanner: RTL and testbench

- Downstream consumer of the Nexys4 display-port AXI-Lite register block.
- Takes the 8 hex digit values, digit-enable mask and decimal-point mask published by that block.
- Time-multiplexes them onto the Nexys4 8-digit common-anode seven-segment display.
- Latches new register contents only at frame boundaries, via a req/ack handshake, so no frame ever shows a mix of old and new values.

---
 rtl/nexys4_seg_scanner.sv | 160 ++++++++++++++++
 tb/tb_nexys4_seg_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nexys4_seg_scanner.sv
// Purpose: scan 8 shadowed hex digits onto the Nexys4 common-anode 7-segment display.
// Latency: outputs are registered one cycle behind the (idx, cnt, shadow) state.
// Backpressure: upd_req is held by the producer and is only served on the frame-boundary cycle.
module nexys4_seg_scanner #(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'd7;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Slot timing state.
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  // Shadow copy of the register block's display fields; only these drive the panel.
  logic [31:0] sh_digits;
  logic [7:0]  sh_en;
  logic [7:0]  sh_dp;

  logic slot_end;
  logic frame_end;
  logic capture;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // A request raised on the boundary cycle itself is still honoured.
  assign capture   = frame_end && upd_req;

  // Hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter and digit index; idx wraps 7 -> 0 naturally in 3 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Shadow load at the frame boundary only, so a frame never mixes old and new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_digits <= '0;
      sh_en     <= '0;
      sh_dp     <= '0;
    end else if (capture) begin
      sh_digits <= digits_in;
      sh_en     <= digit_en;
      sh_dp     <= dp_in;
    end
  end

  // Handshake and frame pulses, issued together on the cycle after the boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      upd_ack    <= capture;
      frame_tick <= frame_end;
    end
  end

  // Select the nibble and flags of the digit currently being scanned.
  logic [3:0] cur_digit;
  logic       cur_en;
  logic       cur_dp;
  always_comb begin
    cur_digit = 4'h0;
    case (idx)
      3'd0:    cur_digit = sh_digits[3:0];
      3'd1:    cur_digit = sh_digits[7:4];
      3'd2:    cur_digit = sh_digits[11:8];
      3'd3:    cur_digit = sh_digits[15:12];
      3'd4:    cur_digit = sh_digits[19:16];
      3'd5:    cur_digit = sh_digits[23:20];
      3'd6:    cur_digit = sh_digits[27:24];
      default: cur_digit = sh_digits[31:28];
    endcase
    cur_en = sh_en[idx];
    cur_dp = sh_dp[idx];
  end

  // Next panel drive: dark during the anti-ghosting window and for disabled digits.
  logic [7:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic       lit;
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    lit     = (cnt >= CNT_BLANK) && cur_en;
    if (lit) begin
      an_nxt      = AN_OFF;
      an_nxt[idx] = 1'b0;
      seg_nxt     = hex_to_seg(cur_digit);
      dp_nxt      = ~cur_dp;
    end
  end

  // Registered panel outputs; a single an_n bit low at most, by construction of an_nxt.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_n  <= AN_OFF;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_nxt;
      seg_n <= seg_nxt;
      dp_n  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_nexys4_seg_scanner.sv
// Bench for nexys4_seg_scanner with a frame-position reference model.
module tb_nexys4_seg_scanner;

  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 8 * R;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits_in = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  nexys4_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en), .dp_in(dp_in),
    .upd_req(upd_req), .upd_ack(upd_ack), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_tick = 0;
  int run_len = 0;
  int lit_cnt = 0;
  logic [7:0] low_seen = '0;
  logic [7:0] dp_seen = '0;

  // Reference model: position within the frame plus the shadowed display contents.
  int          m_pos = 0;
  logic [31:0] m_dig = '0;
  logic [7:0]  m_en = '0;
  logic [7:0]  m_dp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock edge: predict, sample #1 after the edge, then advance the model.
  task automatic step();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick, e_ack, was_rst;
    int slot, c;
    was_rst = reset;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0; e_ack = 1'b0;
    if (!reset) begin
      slot = m_pos / R;
      c    = m_pos % R;
      if (c >= B && m_en[slot]) begin
        e_an       = 8'hFF;
        e_an[slot] = 1'b0;
        e_seg      = HEX[m_dig[4*slot +: 4]];
        e_dp       = ~m_dp[slot];
      end
      e_tick = (m_pos == F - 1);
      e_ack  = e_tick && upd_req;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("an_n", {24'h0, an_n}, {24'h0, e_an});
    chk("seg_n", {25'h0, seg_n}, {25'h0, e_seg});
    chk("dp_n", {31'h0, dp_n}, {31'h0, e_dp});
    chk("frame_tick", {31'h0, frame_tick}, {31'h0, e_tick});
    chk("upd_ack", {31'h0, upd_ack}, {31'h0, e_ack});
    chk("one_anode", ($countones(~an_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (an_n != 8'hFF) lit_cnt++;
    low_seen = low_seen | ~an_n;
    if (!dp_n) dp_seen = dp_seen | ~an_n;
    if (was_rst) begin
      m_pos = 0; m_dig = '0; m_en = '0; m_dp = '0;
      last_tick = cyc;
      run_len = 0;
    end else begin
      if (e_ack) begin
        m_dig = digits_in; m_en = digit_en; m_dp = dp_in;
      end
      m_pos = (m_pos + 1) % F;
      if (frame_tick) begin
        chk("tick_period", cyc - last_tick, F);
        last_tick = cyc;
      end
      if (an_n != 8'hFF) run_len++;
      else if (run_len > 0) begin
        chk("anode_run", run_len, R - B);
        run_len = 0;
      end
    end
    if (upd_ack) upd_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until an ack, bounded by three frames; returns cycles taken (0 = none).
  task automatic wait_ack(output int took);
    took = 0;
    for (int i = 1; i <= 3 * F; i++) begin
      step();
      if (upd_ack) begin
        took = i;
        break;
      end
    end
    chk("ack_seen", (took > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic capture(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    int t;
    digits_in = d; digit_en = e; dp_in = p; upd_req = 1'b1;
    wait_ack(t);
  endtask

  initial begin
    int t;
    // Reset state.
    run(2);

    // Capture and scan: ack + tick exactly one frame after release.
    reset = 1'b0;
    digits_in = 32'h76543210; digit_en = 8'hFF; dp_in = 8'h00; upd_req = 1'b1;
    wait_ack(t);
    chk("first_ack_latency", t, F);
    dp_seen = '0;
    run(3);
    chk("scan_slot0_seg", {25'h0, seg_n}, 32'h40);
    run(F - 3);
    chk("scan_no_dp", {24'h0, dp_seen}, 32'h0);

    // Decoder coverage and decimal points.
    capture(32'hFEDCBA98, 8'hFF, 8'hA5);
    dp_seen = '0;
    run(F);
    chk("dp_slots", {24'h0, dp_seen}, 32'hA5);

    // Enable mask.
    capture(32'h89ABCDEF, 8'h0F, 8'hFF);
    low_seen = '0;
    run(2 * F);
    chk("en_mask_hi", {28'h0, low_seen[7:4]}, 32'h0);
    chk("en_mask_lo", {28'h0, low_seen[3:0]}, 32'hF);

    // Tear-free update: the value on the boundary cycle wins.
    capture(32'h11111111, 8'hFF, 8'h00);
    run(20);
    digits_in = 32'h22222222; upd_req = 1'b1;
    run(20);
    digits_in = 32'h33333333;
    wait_ack(t);
    run(3);
    chk("tear_new_value", {25'h0, seg_n}, 32'h30);
    run(F);

    // No request across several boundaries while inputs churn.
    upd_req = 1'b0;
    for (int k = 0; k < 4 * F / 8; k++) begin
      digits_in = $urandom; digit_en = 8'($urandom); dp_in = 8'($urandom);
      run(8);
    end

    // Reset mid-slot (idx=3, cnt=4) with a request pending.
    digits_in = 32'hCAFE1234; digit_en = 8'hFF; upd_req = 1'b1;
    for (int i = 0; i < 2 * F && m_pos != 3 * R + 4; i++) step();
    chk("reached_mid_slot", m_pos, 3 * R + 4);
    upd_req = 1'b1;
    reset = 1'b1;
    step();
    chk("rst_an_off", {24'h0, an_n}, 32'hFF);
    chk("rst_no_ack", {31'h0, upd_ack}, 32'h0);
    reset = 1'b0;
    upd_req = 1'b0;
    lit_cnt = 0;
    t = 0;
    for (int i = 1; i <= 3 * F; i++) begin
      step();
      if (frame_tick) begin
        t = i;
        break;
      end
    end
    chk("tick_after_reset", t, F);
    run(F);
    chk("blank_until_capture", lit_cnt, 0);
    capture(32'h0000ABCD, 8'h0F, 8'h03);
    run(F);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_in = $urandom; digit_en = 8'($urandom); dp_in = 8'($urandom);
      end
      if (!upd_req && $urandom_range(0, 40) == 0) upd_req = 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    run(F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
